// File: rtl/line_scanout_if.sv
// Line-buffer port bundle between the scan-out reader and the ping-pong RAM.
// The master side issues the read address and the clear-behind-read write.
interface line_scanout_if;
  logic [10:0] LB_ReadAddr;   // {bank, x}
  logic [31:0] LB_ReadData;   // {R12,G12,B8}, valid 1 clk after address
  logic [10:0] LB_WriteAddr;  // clear-behind-read address
  logic [31:0] LB_WriteData;  // background word
  logic        LB_we;         // clear write enable

  modport master (
    output LB_ReadAddr,
    input  LB_ReadData,
    output LB_WriteAddr,
    output LB_WriteData,
    output LB_we
  );

  modport slave (
    input  LB_ReadAddr,
    output LB_ReadData,
    input  LB_WriteAddr,
    input  LB_WriteData,
    input  LB_we
  );
endinterface

// File: rtl/line_scanout.sv
// Read side of the ping-pong pixel line buffer: raster timing generator,
// bank reader with clear-behind-read, and the nextLine/nextFrame strobes
// that steer the rasteriser's bank polarity.
module line_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 4,
  parameter bit          SYNC_NEG = 1'b1,
  parameter logic [31:0] BG_COLOR = 32'h0
) (
  input  logic               clk100,
  input  logic               rst_n,
  line_scanout_if.master     lb,
  output logic               nextLine,
  output logic               nextFrame,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [23:0]        rgb
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_M1 = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_PRE    = 10'(V_TOTAL - 2);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcnt_q, hcnt_d;
  logic [9:0]       vcnt_q, vcnt_d;
  logic             rd_bank_q, rd_bank_d;
  logic             fetch_q, fetch_d;
  logic [10:0]      wr_addr_q, wr_addr_d;
  logic [23:0]      hold_q, hold_d;
  logic             act_p_q, act_p_d;
  logic             hs_p_q, hs_p_d;
  logic             vs_p_q, vs_p_d;
  logic             de_q, de_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             next_line_q, next_line_d;
  logic             next_frame_q, next_frame_d;

  logic pe;
  logic active;
  logic h_sync_on;
  logic v_sync_on;
  logic unused_low_colour_bits;

  assign pe        = (div_q == DIV_LAST);
  assign active    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign h_sync_on = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
  assign v_sync_on = (vcnt_q >= VS_START) && (vcnt_q < VS_END);

  // The low colour bits are dropped when narrowing 12-bit channels to 8.
  assign unused_low_colour_bits = ^{lb.LB_ReadData[23:20], lb.LB_ReadData[11:8]};

  // Next-state: pixel divider, raster counters, fetch/clear, output pipeline, strobes
  always_comb begin
    div_d        = pe ? '0 : div_q + DIV_W'(1);
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    rd_bank_d    = rd_bank_q;
    fetch_d      = pe && active;
    wr_addr_d    = wr_addr_q;
    hold_d       = hold_q;
    act_p_d      = act_p_q;
    hs_p_d       = hs_p_q;
    vs_p_d       = vs_p_q;
    de_d         = de_q;
    rgb_d        = rgb_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    next_line_d  = 1'b0;
    next_frame_d = 1'b0;

    // Read data lands one clk after the address; capture it in the RGB8 layout.
    if (fetch_q) begin
      hold_d = {lb.LB_ReadData[31:24], lb.LB_ReadData[19:12], lb.LB_ReadData[7:0]};
    end

    if (pe) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end

      // Counters move on this edge, so the clear address is latched here.
      wr_addr_d = {rd_bank_q, hcnt_q};

      // Stage 1 records this pixel's qualifiers; stage 2 shows the previous pixel,
      // whose data has reached hold_q by now.
      act_p_d = active;
      hs_p_d  = h_sync_on;
      vs_p_d  = v_sync_on;
      de_d    = act_p_q;
      rgb_d   = act_p_q ? hold_q : '0;
      hsync_d = hs_p_q ^ SYNC_NEG;
      vsync_d = vs_p_q ^ SYNC_NEG;

      if (hcnt_q == H_ACT) begin
        if (vcnt_q == V_PRE) begin
          next_frame_d = 1'b1;
          rd_bank_d    = 1'b0;
        end else if ((vcnt_q == V_LAST) || (vcnt_q < V_ACT_M1)) begin
          next_line_d = 1'b1;
          rd_bank_d   = ~rd_bank_q;
        end
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      div_q        <= '0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      rd_bank_q    <= 1'b0;
      fetch_q      <= 1'b0;
      wr_addr_q    <= '0;
      hold_q       <= '0;
      act_p_q      <= 1'b0;
      hs_p_q       <= 1'b0;
      vs_p_q       <= 1'b0;
      de_q         <= 1'b0;
      rgb_q        <= '0;
      hsync_q      <= SYNC_NEG;
      vsync_q      <= SYNC_NEG;
      next_line_q  <= 1'b0;
      next_frame_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      rd_bank_q    <= rd_bank_d;
      fetch_q      <= fetch_d;
      wr_addr_q    <= wr_addr_d;
      hold_q       <= hold_d;
      act_p_q      <= act_p_d;
      hs_p_q       <= hs_p_d;
      vs_p_q       <= vs_p_d;
      de_q         <= de_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      next_line_q  <= next_line_d;
      next_frame_q <= next_frame_d;
    end
  end

  assign lb.LB_ReadAddr  = {rd_bank_q, hcnt_q};
  assign lb.LB_WriteAddr = wr_addr_q;
  assign lb.LB_WriteData = BG_COLOR;
  assign lb.LB_we        = fetch_q;

  assign nextLine  = next_line_q;
  assign nextFrame = next_frame_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign rgb       = rgb_q;

endmodule

// File: tb/tb_line_scanout.sv
// Directed bench for line_scanout on a shrunken raster (24 x 10 pixels, 16 x 6 active).
// cyc counts clk edges since reset release; pixel k is processed on edge CD*(k+1).
module tb_line_scanout;
  localparam int unsigned HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int unsigned VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int unsigned CD = 4;
  localparam int unsigned HT = HA + HF + HS + HB;  // 24
  localparam int unsigned VT = VA + VF + VS + VB;  // 10
  localparam int unsigned FRAME = HT * VT;         // 240
  localparam logic [31:0] BG = 32'h1234_5678;

  logic        clk100 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        nextLine, nextFrame, hsync, vsync, de;
  logic [23:0] rgb;

  line_scanout_if lb();

  line_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .SYNC_NEG(1'b1), .BG_COLOR(BG)
  ) dut (
    .clk100   (clk100),
    .rst_n    (rst_n),
    .lb       (lb),
    .nextLine (nextLine),
    .nextFrame(nextFrame),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .rgb      (rgb)
  );

  always #5 clk100 = ~clk100;

  // Line-buffer RAM model: synchronous read, DUT clear port, bench preload port.
  bit   [31:0] mem [0:2047];
  logic        tb_wr = 1'b0;
  logic [10:0] tb_waddr = '0;
  logic [31:0] tb_wdata = '0;
  always @(posedge clk100) begin
    lb.LB_ReadData <= mem[lb.LB_ReadAddr];
    if (lb.LB_we === 1'b1) mem[lb.LB_WriteAddr] <= lb.LB_WriteData;
    if (tb_wr) mem[tb_waddr] <= tb_wdata;
  end

  int unsigned cyc = 0;
  always @(posedge clk100) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int unsigned hpos(int unsigned k);
    return k % HT;
  endfunction
  function automatic int unsigned vpos(int unsigned k);
    return (k / HT) % VT;
  endfunction
  function automatic logic active_of(int unsigned k);
    return (hpos(k) < HA) && (vpos(k) < VA);
  endfunction
  // After reset: line v reads bank v[0]; from the second frame on, line 0 is bank 1.
  function automatic logic bank_of(int unsigned k);
    return logic'(vpos(k) % 2) ^ (k >= FRAME);
  endfunction

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic run_to(input int unsigned n);
    int unsigned g = 0;
    while (cyc < n) begin
      tick();
      g++;
      if (g > 20000) begin
        $display("FAIL run_to: cycle %0d not reached, at %0d", n, cyc);
        $fatal(1, "cycle budget expired");
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk100);
    rst_n = 1'b0;
    repeat (10) @(posedge clk100);
    @(negedge clk100);
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [10:0] a, input logic [31:0] d);
    tb_waddr = a;
    tb_wdata = d;
    tb_wr    = 1'b1;
    tick();
    tb_wr    = 1'b0;
  endtask

  task automatic test_reset();
    logic exp_we;
    @(negedge clk100);
    rst_n = 1'b0;
    repeat (10) @(posedge clk100);
    #1;
    n_tests++; if (de !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", de); end
    n_tests++; if (rgb !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h want 0", rgb); end
    n_tests++; if (lb.LB_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", lb.LB_we); end
    n_tests++; if ({nextLine, nextFrame} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {nextLine, nextFrame}); end
    n_tests++; if ({hsync, vsync} !== 2'b11) begin n_fail++; $display("FAIL reset_syncs: got %b want 11", {hsync, vsync}); end
    n_tests++; if (lb.LB_ReadAddr !== 11'd0) begin n_fail++; $display("FAIL reset_raddr: got %0d want 0", lb.LB_ReadAddr); end
    @(negedge clk100);
    rst_n = 1'b1;
    // First pixel tick is the 4th edge; its clear write shows right after it.
    for (int unsigned i = 1; i <= 5; i++) begin
      tick();
      exp_we = (i == 4);
      n_tests++;
      if (lb.LB_we !== exp_we) begin
        n_fail++; $display("FAIL first_pe_we: cyc %0d got %b want %b", i, lb.LB_we, exp_we);
      end
    end
  endtask

  task automatic test_timing();
    int unsigned pk, k, m, h, v;
    logic e_nl, e_nf, e_de, e_hs, e_vs, e_we;
    logic [10:0] e_wa;
    int unsigned bad_strobe = 0, bad_disp = 0, bad_we = 0, bad_rd = 0;
    int unsigned first_bad = 0;
    int unsigned nl_cnt = 0, nf_cnt = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0, nf_pix = 0;
    do_reset();
    for (int unsigned c = 1; c <= 2 * FRAME * CD + CD; c++) begin
      tick();
      pk = c / CD;
      e_nl = 1'b0; e_nf = 1'b0; e_we = 1'b0; e_wa = '0;
      if (c % CD == 0) begin
        k = pk - 1; h = hpos(k); v = vpos(k);
        if (h == HA) begin
          if (v == VT - 2) e_nf = 1'b1;
          else if (v == VT - 1 || v < VA - 1) e_nl = 1'b1;
        end
        if (active_of(k)) begin e_we = 1'b1; e_wa = {bank_of(k), 10'(h)}; end
      end
      if (pk >= 2) begin
        m = pk - 2; h = hpos(m); v = vpos(m);
        e_de = active_of(m);
        e_hs = !(h >= HA + HF && h < HA + HF + HS);
        e_vs = !(v >= VA + VF && v < VA + VF + VS);
      end else begin
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
      end
      if (nextLine !== e_nl || nextFrame !== e_nf) begin
        if (bad_strobe == 0) first_bad = c;
        bad_strobe++;
      end
      if (de !== e_de || hsync !== e_hs || vsync !== e_vs || (!e_de && rgb !== 24'h0)) begin
        if (bad_disp == 0) first_bad = c;
        bad_disp++;
      end
      if (lb.LB_we !== e_we || (e_we && (lb.LB_WriteAddr !== e_wa || lb.LB_WriteData !== BG))) begin
        if (bad_we == 0) first_bad = c;
        bad_we++;
      end
      if (c % CD == CD - 1 && active_of(pk) && lb.LB_ReadAddr !== {bank_of(pk), 10'(hpos(pk))}) begin
        if (bad_rd == 0) first_bad = c;
        bad_rd++;
      end
      if (nextLine === 1'b1) nl_cnt++;
      if (nextFrame === 1'b1) begin
        if (nf_cnt == 0) nf_pix = pk - 1;
        nf_cnt++;
      end
      if (c % CD == 0) begin
        if (de === 1'b1) de_cnt++;
        if (hsync === 1'b0) hs_cnt++;
        if (vsync === 1'b0) vs_cnt++;
      end
    end
    n_tests++; if (bad_strobe != 0) begin n_fail++; $display("FAIL timing_strobes: %0d bad cycles (last first at cyc %0d), want 0", bad_strobe, first_bad); end
    n_tests++; if (bad_disp != 0) begin n_fail++; $display("FAIL timing_display: %0d bad cycles (first at cyc %0d), want 0", bad_disp, first_bad); end
    n_tests++; if (bad_we != 0) begin n_fail++; $display("FAIL timing_clear: %0d bad cycles (first at cyc %0d), want 0", bad_we, first_bad); end
    n_tests++; if (bad_rd != 0) begin n_fail++; $display("FAIL timing_raddr: %0d bad cycles (first at cyc %0d), want 0", bad_rd, first_bad); end
    n_tests++; if (nl_cnt != 12) begin n_fail++; $display("FAIL nextline_count: got %0d want 12", nl_cnt); end
    n_tests++; if (nf_cnt != 2) begin n_fail++; $display("FAIL nextframe_count: got %0d want 2", nf_cnt); end
    n_tests++; if (nf_pix != 208) begin n_fail++; $display("FAIL nextframe_pos: got pixel %0d want 208 (h16 v8)", nf_pix); end
    n_tests++; if (de_cnt != 192) begin n_fail++; $display("FAIL de_count: got %0d want 192", de_cnt); end
    n_tests++; if (hs_cnt != 80) begin n_fail++; $display("FAIL hsync_count: got %0d want 80", hs_cnt); end
    n_tests++; if (vs_cnt != 96) begin n_fail++; $display("FAIL vsync_count: got %0d want 96", vs_cnt); end
  endtask

  // Frame 1 (second after reset), line 0 shows bank 1; x=5 is preloaded during line 9 of frame 0.
  task automatic test_fetch_clear();
    do_reset();
    run_to(4 * 216);
    preload(11'd1029, 32'hABCD_EF12);
    preload(11'd1039, 32'hFEDC_BA98);
    run_to(981);
    n_tests++; if (lb.LB_ReadAddr !== 11'd1029) begin n_fail++; $display("FAIL fetch_raddr: got %0d want 1029", lb.LB_ReadAddr); end
    run_to(984);
    n_tests++; if (lb.LB_we !== 1'b1 || lb.LB_WriteAddr !== 11'd1029 || lb.LB_WriteData !== BG) begin
      n_fail++; $display("FAIL fetch_clear: got we=%b addr=%0d data=%h want we=1 addr=1029 data=%h", lb.LB_we, lb.LB_WriteAddr, lb.LB_WriteData, BG);
    end
    run_to(985);
    n_tests++; if (lb.LB_we !== 1'b0) begin n_fail++; $display("FAIL fetch_we_width: got %b want 0", lb.LB_we); end
    run_to(987);
    n_tests++; if (de !== 1'b1 || rgb !== 24'h124578) begin n_fail++; $display("FAIL fetch_prev_pixel: got de=%b rgb=%h want de=1 rgb=124578", de, rgb); end
    run_to(988);
    n_tests++; if (de !== 1'b1 || rgb !== 24'hABDE12) begin n_fail++; $display("FAIL fetch_rgb: got de=%b rgb=%h want de=1 rgb=abde12", de, rgb); end
    n_tests++; if (mem[1029] !== BG) begin n_fail++; $display("FAIL fetch_cleared: got %h want %h", mem[1029], BG); end
  endtask

  // Continues from test_fetch_clear: last active pixel, first inactive pixel, next line bank.
  task automatic test_boundary();
    run_to(1024);
    n_tests++; if (lb.LB_we !== 1'b1 || lb.LB_WriteAddr !== 11'd1039) begin n_fail++; $display("FAIL last_px_clear: got we=%b addr=%0d want we=1 addr=1039", lb.LB_we, lb.LB_WriteAddr); end
    run_to(1028);
    n_tests++; if (de !== 1'b1 || rgb !== 24'hFECB98) begin n_fail++; $display("FAIL last_px_rgb: got de=%b rgb=%h want de=1 rgb=fecb98", de, rgb); end
    n_tests++; if (lb.LB_we !== 1'b0) begin n_fail++; $display("FAIL x16_no_read: got we=%b want 0", lb.LB_we); end
    n_tests++; if ({nextLine, nextFrame} !== 2'b10) begin n_fail++; $display("FAIL line0_strobe: got %b want 10", {nextLine, nextFrame}); end
    run_to(1029);
    n_tests++; if (nextLine !== 1'b0) begin n_fail++; $display("FAIL strobe_width: got %b want 0", nextLine); end
    run_to(1032);
    n_tests++; if (de !== 1'b0 || rgb !== 24'h0) begin n_fail++; $display("FAIL blank_after_active: got de=%b rgb=%h want de=0 rgb=0", de, rgb); end
    n_tests++; if (mem[1039] !== BG) begin n_fail++; $display("FAIL last_px_cleared: got %h want %h", mem[1039], BG); end
    run_to(1069);
    n_tests++; if (lb.LB_ReadAddr !== 11'd3) begin n_fail++; $display("FAIL line1_bank0: got %0d want 3", lb.LB_ReadAddr); end
  endtask

  task automatic test_midline_reset();
    do_reset();
    run_to(330);
    n_tests++; if (lb.LB_ReadAddr !== 11'd1034) begin n_fail++; $display("FAIL midline_pos: got %0d want 1034", lb.LB_ReadAddr); end
    @(negedge clk100);
    rst_n = 1'b0;
    tick();
    n_tests++; if (lb.LB_ReadAddr !== 11'd0) begin n_fail++; $display("FAIL midline_counters: got %0d want 0", lb.LB_ReadAddr); end
    n_tests++; if (lb.LB_we !== 1'b0 || de !== 1'b0 || rgb !== 24'h0) begin n_fail++; $display("FAIL midline_outputs: got we=%b de=%b rgb=%h want 0 0 0", lb.LB_we, de, rgb); end
    n_tests++; if ({nextLine, nextFrame, hsync, vsync} !== 4'b0011) begin n_fail++; $display("FAIL midline_strobe_sync: got %b want 0011", {nextLine, nextFrame, hsync, vsync}); end
    @(negedge clk100);
    rst_n = 1'b1;
    run_to(3);
    n_tests++; if (lb.LB_we !== 1'b0) begin n_fail++; $display("FAIL midline_div_early: got we=%b want 0", lb.LB_we); end
    run_to(4);
    n_tests++; if (lb.LB_we !== 1'b1 || lb.LB_WriteAddr !== 11'd0) begin n_fail++; $display("FAIL midline_restart: got we=%b addr=%0d want we=1 addr=0", lb.LB_we, lb.LB_WriteAddr); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_fetch_clear();
    test_boundary();
    test_midline_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
